// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_redirect_ctrl
//  Purpose  : Sequences control-flow redirects for the RV32I pipeline.
//             Arbitrates trap / jump / taken-branch redirect sources, holds a
//             single registered redirect on a valid/ready handshake towards
//             fetch, flushes IF/ID for a fixed drain window after acceptance,
//             stalls EX while a redirect is in flight and counts accepted
//             taken branches (saturating).
//  Ports    :
//    clk, rst_n        clock (rising edge), asynchronous active-low reset
//    ex_valid_i        valid instruction in EX (qualifies br/jmp)
//    br_taken_i        branch taken flag,   br_target_i   branch target
//    jmp_valid_i       JAL/JALR resolved,   jmp_target_i  jump target
//    trap_valid_i      trap request,        trap_vector_i handler address
//    fetch_ready_i     fetch accepts the pending redirect this cycle
//    redirect_valid_o  redirect pending,    redirect_pc_o redirect address
//    flush_if_o        squash IF,           flush_id_o    squash ID
//    stall_ex_o        hold EX / suppress new resolutions
//    misalign_o        1-cycle pulse: captured jmp/br target has bit1 set
//    br_count_o        accepted taken-branch count (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic             br_taken_i,
    input  logic [XLEN-1:0]  br_target_i,
    input  logic             jmp_valid_i,
    input  logic [XLEN-1:0]  jmp_target_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_vector_i,
    input  logic             fetch_ready_i,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             stall_ex_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] br_count_o
);

    // Drain counter only needs to hold FLUSH_CYCLES; keep at least one bit so
    // the FLUSH_CYCLES=0 build still elaborates.
    localparam int unsigned       DRAIN_W    = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(FLUSH_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [XLEN-1:0]    PC_MASK    = ~XLEN'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic [XLEN-1:0]     target_q;
    logic                src_br_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic [CNT_W-1:0]    br_count_q;
    logic [CNT_W-1:0]    br_count_d;
    logic                valid_q;
    logic                flush_q;
    logic                stall_q;
    logic                misalign_q;

    // Source qualification and fixed priority trap > jmp > br.
    logic            w_trap;
    logic            w_jmp;
    logic            w_br;
    logic            w_any;
    logic            w_sel_br;
    logic [XLEN-1:0] w_sel_target;

    assign w_trap       = trap_valid_i;
    assign w_jmp        = ex_valid_i & jmp_valid_i;
    assign w_br         = ex_valid_i & br_taken_i;
    assign w_any        = w_trap | w_jmp | w_br;
    assign w_sel_br     = ~w_trap & ~w_jmp & w_br;
    assign w_sel_target = w_trap ? trap_vector_i :
                          w_jmp  ? jmp_target_i  : br_target_i;

    // Saturating increment: the count sticks at all-ones.
    assign br_count_d = (br_count_q == CNT_MAX) ? br_count_q : br_count_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            src_br_q    <= 1'b0;
            drain_cnt_q <= '0;
            br_count_q  <= '0;
            valid_q     <= 1'b0;
            flush_q     <= 1'b0;
            stall_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_any) begin
                        target_q   <= w_sel_target & PC_MASK;
                        src_br_q   <= w_sel_br;
                        // Only EX-resolved targets can be misaligned; trap
                        // vectors are trusted.
                        misalign_q <= ~w_trap & w_sel_target[1];
                        state_q    <= ST_PEND;
                        valid_q    <= 1'b1;
                        flush_q    <= 1'b1;
                        stall_q    <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (w_trap) begin
                        // Trap preempts, even in the accept cycle: the old
                        // redirect is dropped uncounted, valid stays high.
                        target_q <= trap_vector_i & PC_MASK;
                        src_br_q <= 1'b0;
                    end else if (fetch_ready_i) begin
                        if (src_br_q) begin
                            br_count_q <= br_count_d;
                        end
                        valid_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            flush_q <= 1'b0;
                            stall_q <= 1'b0;
                        end else begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_trap) begin
                        target_q <= trap_vector_i & PC_MASK;
                        src_br_q <= 1'b0;
                        state_q  <= ST_PEND;
                        valid_q  <= 1'b1;
                    end else if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                        stall_q <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    flush_q <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid_o = valid_q;
    assign redirect_pc_o    = target_q;
    assign flush_if_o       = flush_q;
    assign flush_id_o       = flush_q;
    assign stall_ex_o       = stall_q;
    assign misalign_o       = misalign_q;
    assign br_count_o       = br_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_redirect_ctrl
//  Purpose  : Self-checking bench for branch_redirect_ctrl. Three instances
//             share one stimulus stream: default build, CNT_W=2 build and
//             FLUSH_CYCLES=0 build. Directed table, hand sequences for reset
//             and counter saturation, then random traffic vs. a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ex, bt, jv, tv, rdy;
    logic [31:0] bta, jta, tva;

    logic [2:0]        v_w, fi_w, fd_w, st_w, mis_w;
    logic [2:0][31:0]  pc_w;
    logic [31:0]       cnt0, cnt2;
    logic [1:0]        cnt1;
    logic [2:0][31:0]  cnt_w;

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = {30'd0, cnt1};
    assign cnt_w[2] = cnt2;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex), .br_taken_i(bt), .br_target_i(bta),
        .jmp_valid_i(jv), .jmp_target_i(jta), .trap_valid_i(tv), .trap_vector_i(tva),
        .fetch_ready_i(rdy), .redirect_valid_o(v_w[0]), .redirect_pc_o(pc_w[0]),
        .flush_if_o(fi_w[0]), .flush_id_o(fd_w[0]), .stall_ex_o(st_w[0]),
        .misalign_o(mis_w[0]), .br_count_o(cnt0));

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex), .br_taken_i(bt), .br_target_i(bta),
        .jmp_valid_i(jv), .jmp_target_i(jta), .trap_valid_i(tv), .trap_vector_i(tva),
        .fetch_ready_i(rdy), .redirect_valid_o(v_w[1]), .redirect_pc_o(pc_w[1]),
        .flush_if_o(fi_w[1]), .flush_id_o(fd_w[1]), .stall_ex_o(st_w[1]),
        .misalign_o(mis_w[1]), .br_count_o(cnt1));

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex), .br_taken_i(bt), .br_target_i(bta),
        .jmp_valid_i(jv), .jmp_target_i(jta), .trap_valid_i(tv), .trap_vector_i(tva),
        .fetch_ready_i(rdy), .redirect_valid_o(v_w[2]), .redirect_pc_o(pc_w[2]),
        .flush_if_o(fi_w[2]), .flush_id_o(fd_w[2]), .stall_ex_o(st_w[2]),
        .misalign_o(mis_w[2]), .br_count_o(cnt2));

    // ---------------- reference model (per instance) ----------------
    int          FCV  [3] = '{2, 2, 0};
    longint      CMAX [3] = '{64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFF};
    bit          m_pend [3];
    int          m_drain[3];
    logic [31:0] m_pc   [3];
    bit          m_isbr [3];
    longint      m_cnt  [3];
    bit          m_mis  [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 0; m_drain[k] = 0; m_pc[k] = '0;
            m_isbr[k] = 0; m_cnt[k] = 0; m_mis[k] = 0;
        end
    endtask

    // One clock of the redirect rules, sampled on the inputs seen at the edge.
    task automatic model_step();
        bit t, j, b;
        logic [31:0] sel;
        t = tv; j = ex & jv; b = ex & bt;
        for (int k = 0; k < 3; k++) begin
            m_mis[k] = 0;
            if (m_pend[k]) begin
                if (t) begin
                    m_pc[k] = tva & 32'hFFFF_FFFE; m_isbr[k] = 0;
                end else if (rdy) begin
                    if (m_isbr[k] && m_cnt[k] < CMAX[k]) m_cnt[k] = m_cnt[k] + 1;
                    m_pend[k]  = 0;
                    m_drain[k] = FCV[k];
                end
            end else if (m_drain[k] > 0) begin
                if (t) begin
                    m_pc[k] = tva & 32'hFFFF_FFFE; m_isbr[k] = 0;
                    m_pend[k] = 1; m_drain[k] = 0;
                end else begin
                    m_drain[k] = m_drain[k] - 1;
                end
            end else if (t || j || b) begin
                sel = t ? tva : (j ? jta : bta);
                m_pc[k]   = sel & 32'hFFFF_FFFE;
                m_isbr[k] = !t && !j;
                m_mis[k]  = !t && sel[1];
                m_pend[k] = 1;
            end
        end
    endtask

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        bit busy;
        for (int k = 0; k < 3; k++) begin
            busy = m_pend[k] || (m_drain[k] > 0);
            chk("valid",    k, {31'd0, v_w[k]},   {31'd0, m_pend[k]});
            chk("flush_if", k, {31'd0, fi_w[k]},  {31'd0, busy});
            chk("flush_id", k, {31'd0, fd_w[k]},  {31'd0, busy});
            chk("stall_ex", k, {31'd0, st_w[k]},  {31'd0, busy});
            chk("pc",       k, pc_w[k],           m_pc[k]);
            chk("misalign", k, {31'd0, mis_w[k]}, {31'd0, m_mis[k]});
            chk("br_count", k, cnt_w[k],          m_cnt[k][31:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic idle_in(input logic r);
        ex = 0; bt = 0; jv = 0; tv = 0; rdy = r;
        bta = '0; jta = '0; tva = '0;
    endtask

    task automatic do_reset();
        idle_in(1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- directed table (default instance) ----------------
    typedef struct {
        logic        ex, bt; logic [31:0] bta;
        logic        jv;     logic [31:0] jta;
        logic        tv;     logic [31:0] tva;
        logic        rdy;
        logic        e_valid, e_flush, e_mis;
        logic [31:0] e_pc, e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic e, logic b, logic [31:0] ba, logic j, logic [31:0] ja,
                                logic t, logic [31:0] ta, logic r,
                                logic ev, logic ef, logic em, logic [31:0] epc, logic [31:0] ec);
        vec_t x;
        x.ex = e; x.bt = b; x.bta = ba; x.jv = j; x.jta = ja; x.tv = t; x.tva = ta; x.rdy = r;
        x.e_valid = ev; x.e_flush = ef; x.e_mis = em; x.e_pc = epc; x.e_cnt = ec;
        return x;
    endfunction

    initial begin
        // branch, no backpressure
        tbl.push_back(mk(1,1,32'h120,0,0,0,0,1, 1,1,0,32'h120,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,       0,1,0,32'h120,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,1,0,32'h120,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,32'h120,1));
        // jump with 3 cycles of backpressure, bit0 dropped
        tbl.push_back(mk(1,0,0,1,32'h201,0,0,0, 1,1,0,32'h200,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       1,1,0,32'h200,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       1,1,0,32'h200,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       1,1,0,32'h200,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,       0,1,0,32'h200,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,1,0,32'h200,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,32'h200,1));
        // misaligned branch target still redirects
        tbl.push_back(mk(1,1,32'h102,0,0,0,0,0, 1,1,1,32'h102,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,       0,1,0,32'h102,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,1,0,32'h102,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,32'h102,2));
        // trap + jmp + br together: trap wins
        tbl.push_back(mk(1,1,32'h400,1,32'h300,1,32'h45,0, 1,1,0,32'h44,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,       0,1,0,32'h44,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,1,0,32'h44,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,32'h44,2));
        // br + jmp together: jmp wins, not counted
        tbl.push_back(mk(1,1,32'h500,1,32'h602,0,0,0, 1,1,1,32'h602,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,       0,1,0,32'h602,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,1,0,32'h602,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,32'h602,2));
        // trap preempts branch in the accept cycle
        tbl.push_back(mk(1,1,32'h80,0,0,0,0,0,  1,1,0,32'h80,2));
        tbl.push_back(mk(0,0,0,0,0,1,32'h4,1,   1,1,0,32'h4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,       0,1,0,32'h4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,1,0,32'h4,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,       0,0,0,32'h4,2));
    end

    initial begin
        rst_n = 1'b0;
        idle_in(1'b0);
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", k, {31'd0, v_w[k]},  32'd0);
            chk("reset_pc",    k, pc_w[k],          32'd0);
            chk("reset_cnt",   k, cnt_w[k],         32'd0);
            chk("reset_flush", k, {31'd0, fi_w[k]}, 32'd0);
        end
        do_reset();

        // -------- directed table --------
        for (int i = 0; i < tbl.size(); i++) begin
            ex = tbl[i].ex; bt = tbl[i].bt; bta = tbl[i].bta;
            jv = tbl[i].jv; jta = tbl[i].jta;
            tv = tbl[i].tv; tva = tbl[i].tva; rdy = tbl[i].rdy;
            step();
            chk("tbl_valid", 0, {31'd0, v_w[0]},   {31'd0, tbl[i].e_valid});
            chk("tbl_flush", 0, {31'd0, fi_w[0]},  {31'd0, tbl[i].e_flush});
            chk("tbl_stall", 0, {31'd0, st_w[0]},  {31'd0, tbl[i].e_flush});
            chk("tbl_mis",   0, {31'd0, mis_w[0]}, {31'd0, tbl[i].e_mis});
            chk("tbl_pc",    0, pc_w[0],           tbl[i].e_pc);
            chk("tbl_cnt",   0, cnt_w[0],          tbl[i].e_cnt);
        end

        // -------- reset mid-PEND --------
        idle_in(1'b0);
        ex = 1; bt = 1; bta = 32'h88;
        step();
        idle_in(1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("arst_valid", k, {31'd0, v_w[k]},   32'd0);
            chk("arst_stall", k, {31'd0, st_w[k]},  32'd0);
            chk("arst_flush", k, {31'd0, fd_w[k]},  32'd0);
            chk("arst_pc",    k, pc_w[k],           32'd0);
            chk("arst_cnt",   k, cnt_w[k],          32'd0);
            chk("arst_mis",   k, {31'd0, mis_w[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_in(1'b1);
        repeat (3) step();
        chk("post_rst_no_redirect", 0, {31'd0, v_w[0]}, 32'd0);

        // -------- five accepted branches: CNT_W=2 saturates, FLUSH=0 drops flush --------
        for (int i = 0; i < 5; i++) begin
            idle_in(1'b0);
            ex = 1; bt = 1; bta = 32'h1000 + 32'(i) * 32'h40;
            step();
            idle_in(1'b1);
            step();
            chk("fc0_flush_after_accept", 2, {31'd0, fi_w[2]}, 32'd0);
            idle_in(1'b0);
            repeat (2) step();
        end
        chk("sat_cnt_w2", 1, cnt_w[1], 32'd3);
        chk("cnt_5",      0, cnt_w[0], 32'd5);

        // -------- random traffic vs. model --------
        for (int i = 0; i < 1500; i++) begin
            ex  = ($urandom % 2) == 0;
            bt  = ($urandom % 2) == 0;
            jv  = ($urandom % 4) == 0;
            tv  = ($urandom % 10) == 0;
            rdy = ($urandom % 3) != 0;
            bta = $urandom; jta = $urandom; tva = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
